match_round_controller: RTL and testbench

Sequences one round of the tile-matching game. It turns select presses on the slide switches into first/second tile picks, rejects illegal picks, and holds both tiles revealed for a fixed time. It then compares colours, updates the matched mask, counts attempts in BCD and flags game over. It sits between the board I/O (SW, select key, LEDR, HEX2–HEX5) and the board-layout block that supplies per-tile colours, and replaces ad-hoc pick logic in the in-game FSM.

---
 rtl/match_round_controller_if.sv | 28 ++
 rtl/match_round_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_match_round_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_round_controller_if.sv
// Board-side signal bundle for match_round_controller.
// master: the board/test driver that owns switches, keys and colours.
// slave: the round controller that owns lamps, hex digits, score and state.
interface match_round_controller_if #(
    parameter int NTILES = 10
);
    logic                  start;
    logic                  quit;
    logic                  selectSW;
    logic [NTILES-1:0]     SW;
    logic [3*NTILES-1:0]   tile_colors;
    logic [NTILES-1:0]     led;
    logic [3:0]            first_hex;
    logic [3:0]            second_hex;
    logic [7:0]            score_bcd;
    logic                  game_over;
    logic [2:0]            state;

    modport master (
        output start, quit, selectSW, SW, tile_colors,
        input  led, first_hex, second_hex, score_bcd, game_over, state
    );

    modport slave (
        input  start, quit, selectSW, SW, tile_colors,
        output led, first_hex, second_hex, score_bcd, game_over, state
    );
endinterface

// File: rtl/match_round_controller.sv
// match_round_controller: sequences one round of the tile-matching game.
// Select presses become first/second picks; both tiles stay revealed for
// REVEAL_CYCLES clocks, then colours are compared, the matched mask is
// updated, attempts are counted in saturating BCD and game over is flagged.
// Optional feature macro: REVEAL_SKIP_EN (a select press during REVEAL ends
// the reveal early). The default build leaves it undefined.
module match_round_controller #(
    parameter int NTILES        = 10,
    parameter int REVEAL_CYCLES = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic                    CLOCK_50,
    input  logic                    clear,
    match_round_controller_if.slave bus
);

    localparam int IDX_W = (NTILES > 1) ? $clog2(NTILES) : 1;
    localparam logic [NTILES-1:0] TILE_ONE  = {{(NTILES-1){1'b0}}, 1'b1};
    localparam logic [NTILES-1:0] ALL_TILES = {NTILES{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PICK1    = 3'd1,
        PICK2    = 3'd2,
        REVEAL   = 3'd3,
        GAMEOVER = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               sel_s1_q, sel_s2_q, sel_s3_q;
    logic               sel_fall_q, sel_fall_d;
    logic [NTILES-1:0]  sw_s1_q, sw_s2_q;
    logic [NTILES-1:0]  matched_q, matched_d;
    logic [IDX_W-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic               p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         score_q, score_d;
    logic [NTILES-1:0]  led_q, led_d;
    logic [3:0]         first_hex_q, first_hex_d;
    logic [3:0]         second_hex_q, second_hex_d;
    logic               game_over_q, game_over_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               reveal_done;
    logic [2:0]         col1, col2;

    function automatic logic [NTILES-1:0] tile_bit(input logic [IDX_W-1:0] idx);
        return TILE_ONE << idx;
    endfunction

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign col1 = bus.tile_colors[3*int'(p1_q) +: 3];
    assign col2 = bus.tile_colors[3*int'(p2_q) +: 3];

    // Falling edge of the synchronised select key (previous high, now low).
    always_comb begin
        sel_fall_d = sel_s3_q & ~sel_s2_q;
    end

    // Lowest switched-on tile that is unmatched and not the held first pick.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NTILES - 1; i >= 0; i--) begin
            if (sw_s2_q[i] && !matched_q[i] && !(p1_vld_q && (p1_q == IDX_W'(i)))) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    // Round FSM next-state, pick/score/counter/mask updates.
    always_comb begin
        state_d     = state_q;
        matched_d   = matched_q;
        p1_d        = p1_q;
        p1_vld_d    = p1_vld_q;
        p2_d        = p2_q;
        p2_vld_d    = p2_vld_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        reveal_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.quit)
                    state_d = PICK1;
            end
            PICK1: begin
                if (bus.quit)
                    state_d = IDLE;
                else if (sel_fall_q && pick_found) begin
                    p1_d     = pick_idx;
                    p1_vld_d = 1'b1;
                    state_d  = PICK2;
                end
            end
            PICK2: begin
                if (bus.quit)
                    state_d = IDLE;
                else if (sel_fall_q && pick_found) begin
                    p2_d     = pick_idx;
                    p2_vld_d = 1'b1;
                    score_d  = bcd_inc(score_q);
                    cnt_d    = CNT_W'(REVEAL_CYCLES - 1);
                    state_d  = REVEAL;
                end
            end
            REVEAL: begin
                if (bus.quit)
                    state_d = IDLE;
                else begin
`ifdef REVEAL_SKIP_EN
                    reveal_done = (cnt_q == '0) || sel_fall_q;
`else
                    reveal_done = (cnt_q == '0);
`endif
                    if (reveal_done) begin
                        if (col1 == col2)
                            matched_d = matched_q | tile_bit(p1_q) | tile_bit(p2_q);
                        p1_d     = '0;
                        p1_vld_d = 1'b0;
                        p2_d     = '0;
                        p2_vld_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = (matched_d == ALL_TILES) ? GAMEOVER : PICK1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            GAMEOVER: begin
                if (bus.start || bus.quit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entering or sitting in IDLE wipes the round, so IDLE always shows a fresh board.
        if (state_d == IDLE) begin
            matched_d = '0;
            p1_d      = '0;
            p1_vld_d  = 1'b0;
            p2_d      = '0;
            p2_vld_d  = 1'b0;
            cnt_d     = '0;
            score_d   = 8'h00;
        end
    end

    // Registered outputs computed from next-state values so they change with the state.
    always_comb begin
        led_d        = '0;
        first_hex_d  = 4'hF;
        second_hex_d = 4'hF;
        game_over_d  = (state_d == GAMEOVER);
        if (state_d == PICK1 || state_d == PICK2 || state_d == REVEAL) begin
            led_d = matched_d
                  | (p1_vld_d ? tile_bit(p1_d) : '0)
                  | (p2_vld_d ? tile_bit(p2_d) : '0);
        end
        if (state_d == PICK2 || state_d == REVEAL)
            first_hex_d = {1'b0, bus.tile_colors[3*int'(p1_d) +: 3]};
        if (state_d == REVEAL)
            second_hex_d = {1'b0, bus.tile_colors[3*int'(p2_d) +: 3]};
    end

    // Synchronisers and all round state; select idles high so its chain resets to 1.
    always_ff @(posedge CLOCK_50 or negedge clear) begin
        if (!clear) begin
            sel_s1_q     <= 1'b1;
            sel_s2_q     <= 1'b1;
            sel_s3_q     <= 1'b1;
            sel_fall_q   <= 1'b0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            state_q      <= IDLE;
            matched_q    <= '0;
            p1_q         <= '0;
            p1_vld_q     <= 1'b0;
            p2_q         <= '0;
            p2_vld_q     <= 1'b0;
            cnt_q        <= '0;
            score_q      <= 8'h00;
            led_q        <= '0;
            first_hex_q  <= 4'hF;
            second_hex_q <= 4'hF;
            game_over_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sel_s1_q     <= bus.selectSW;
            sel_s2_q     <= sel_s1_q;
            sel_s3_q     <= sel_s2_q;
            sel_fall_q   <= sel_fall_d;
            sw_s1_q      <= bus.SW;
            sw_s2_q      <= sw_s1_q;
            state_q      <= state_d;
            matched_q    <= matched_d;
            p1_q         <= p1_d;
            p1_vld_q     <= p1_vld_d;
            p2_q         <= p2_d;
            p2_vld_q     <= p2_vld_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            led_q        <= led_d;
            first_hex_q  <= first_hex_d;
            second_hex_q <= second_hex_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.first_hex  = first_hex_q;
    assign bus.second_hex = second_hex_q;
    assign bus.score_bcd  = score_q;
    assign bus.game_over  = game_over_q;
    assign bus.state      = 3'(state_q);

endmodule

// File: tb/tb_match_round_controller.sv
// Directed bench for match_round_controller with REVEAL_CYCLES=8.
// Tile colours t0..t9 = 1,2,3,4,2,4,3,1,5,5; pairs (0,7) (1,4) (2,6) (3,5) (8,9).
module tb_match_round_controller;

    localparam int NT = 10;
    localparam int RC = 8;

    logic clk;
    logic clear;
    int   checks;
    int   errors;
    int   n_att;

    match_round_controller_if #(.NTILES(NT)) bus ();

    match_round_controller #(
        .NTILES        (NT),
        .REVEAL_CYCLES (RC),
        .CNT_W         (4)
    ) dut (
        .CLOCK_50 (clk),
        .clear    (clear),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd_of(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return 8'((m / 10) * 16 + (m % 10));
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One select press: key low for four edges with sw on the switches; returns
    // at the negedge just after the edge where the pick takes effect.
    task automatic press(input logic [NT-1:0] sw);
        @(negedge clk);
        bus.SW       = sw;
        bus.selectSW = 1'b0;
        wait_neg(4);
        bus.selectSW = 1'b1;
    endtask

    // A full attempt: two picks, reveal checks, back to PICK1.
    task automatic attempt(input logic [NT-1:0] a, input logic [NT-1:0] b,
                           input logic [7:0] exp_score);
        press(a);
        press(b);
        check("att_state_reveal", 32'(bus.state), 32'd3);
        check("att_score", 32'(bus.score_bcd), 32'(exp_score));
        wait_neg(RC);
        check("att_state_pick1", 32'(bus.state), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear           = 1'b0;
        bus.start       = 1'b0;
        bus.quit        = 1'b0;
        bus.selectSW    = 1'b1;
        bus.SW          = '0;
        bus.tile_colors = {3'd5, 3'd5, 3'd1, 3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd2, 3'd1};

        // Reset values
        wait_neg(2);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_first_hex", 32'(bus.first_hex), 32'hF);
        check("rst_second_hex", 32'(bus.second_hex), 32'hF);
        check("rst_score", 32'(bus.score_bcd), 32'h00);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        clear = 1'b1;

        // Start
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check("start_pick1", 32'(bus.state), 32'd1);
        check("pick1_first_hex", 32'(bus.first_hex), 32'hF);
        bus.start = 1'b0;

        // First press with exact latency: no change after n+2, pick at n+3
        @(negedge clk);
        bus.SW       = 10'h001;
        bus.selectSW = 1'b0;
        wait_neg(3);
        check("lat_n2_state", 32'(bus.state), 32'd1);
        @(negedge clk);
        check("lat_n3_state", 32'(bus.state), 32'd2);
        check("lat_n3_first_hex", 32'(bus.first_hex), 32'h1);
        check("lat_n3_led", 32'(bus.led), 32'h001);
        check("lat_n3_second_hex", 32'(bus.second_hex), 32'hF);
        bus.selectSW = 1'b1;

        // Second pick tile 1 (colour 2): no match
        press(10'h002);
        check("nm_state", 32'(bus.state), 32'd3);
        check("nm_first_hex", 32'(bus.first_hex), 32'h1);
        check("nm_second_hex", 32'(bus.second_hex), 32'h2);
        check("nm_score", 32'(bus.score_bcd), 32'h01);
        check("nm_led", 32'(bus.led), 32'h003);
        wait_neg(RC - 1);
        check("nm_reveal_last", 32'(bus.state), 32'd3);
        @(negedge clk);
        check("nm_after_state", 32'(bus.state), 32'd1);
        check("nm_after_led", 32'(bus.led), 32'h000);
        check("nm_after_score", 32'(bus.score_bcd), 32'h01);
        check("nm_after_hex1", 32'(bus.first_hex), 32'hF);
        check("nm_after_hex2", 32'(bus.second_hex), 32'hF);

        // Tile 0 again is accepted; then tile 7 matches it
        press(10'h001);
        check("re_pick_state", 32'(bus.state), 32'd2);
        check("re_pick_hex", 32'(bus.first_hex), 32'h1);
        press(10'h080);
        check("m07_state", 32'(bus.state), 32'd3);
        check("m07_first_hex", 32'(bus.first_hex), 32'h1);
        check("m07_second_hex", 32'(bus.second_hex), 32'h1);
        check("m07_score", 32'(bus.score_bcd), 32'h02);
        check("m07_led", 32'(bus.led), 32'h081);
        wait_neg(RC);
        check("m07_after_state", 32'(bus.state), 32'd1);
        check("m07_after_led", 32'(bus.led), 32'h081);

        // Illegal picks: matched tile, then the held first pick
        press(10'h001);
        check("ill_matched_state", 32'(bus.state), 32'd1);
        check("ill_matched_score", 32'(bus.score_bcd), 32'h02);
        press(10'h003);
        check("low_legal_state", 32'(bus.state), 32'd2);
        check("low_legal_hex", 32'(bus.first_hex), 32'h2);
        check("low_legal_led", 32'(bus.led), 32'h083);
        press(10'h002);
        check("ill_same_state", 32'(bus.state), 32'd2);
        check("ill_same_score", 32'(bus.score_bcd), 32'h02);
        press(10'h010);
        check("m14_state", 32'(bus.state), 32'd3);
        check("m14_second_hex", 32'(bus.second_hex), 32'h2);
        check("m14_score", 32'(bus.score_bcd), 32'h03);
        check("m14_led", 32'(bus.led), 32'h093);
        wait_neg(RC);
        check("m14_after_led", 32'(bus.led), 32'h093);

        // Remaining pairs to game over
        attempt(10'h004, 10'h040, 8'h04);
        check("m26_led", 32'(bus.led), 32'h0D7);
        attempt(10'h008, 10'h020, 8'h05);
        check("m35_led", 32'(bus.led), 32'h0FF);
        press(10'h100);
        press(10'h200);
        check("m89_led", 32'(bus.led), 32'h3FF);
        check("m89_score", 32'(bus.score_bcd), 32'h06);
        wait_neg(RC);
        check("go_state", 32'(bus.state), 32'd4);
        check("go_flag", 32'(bus.game_over), 32'd1);
        check("go_led", 32'(bus.led), 32'h000);
        check("go_score", 32'(bus.score_bcd), 32'h06);
        check("go_first_hex", 32'(bus.first_hex), 32'hF);

        // start leaves GAMEOVER for a cleared IDLE, then re-enters play
        bus.start = 1'b1;
        @(negedge clk);
        check("go_idle_state", 32'(bus.state), 32'd0);
        check("go_idle_score", 32'(bus.score_bcd), 32'h00);
        check("go_idle_flag", 32'(bus.game_over), 32'd0);
        @(negedge clk);
        check("idle_start_pick1", 32'(bus.state), 32'd1);

        // quit beats start
        bus.quit = 1'b1;
        @(negedge clk);
        check("quit_pick1", 32'(bus.state), 32'd0);
        @(negedge clk);
        check("quit_over_start", 32'(bus.state), 32'd0);
        bus.quit = 1'b0;
        @(negedge clk);
        check("restart_pick1", 32'(bus.state), 32'd1);
        bus.start = 1'b0;

        // Select two cycles into REVEAL
        press(10'h001);
        press(10'h002);
        check("skip_enter", 32'(bus.state), 32'd3);
        check("skip_score", 32'(bus.score_bcd), 32'h01);
        @(negedge clk);
        bus.SW       = 10'h004;
        bus.selectSW = 1'b0;
        wait_neg(4);
        bus.selectSW = 1'b1;
`ifdef REVEAL_SKIP_EN
        check("skip_forced", 32'(bus.state), 32'd1);
        wait_neg(5);
        check("skip_no_pick_state", 32'(bus.state), 32'd1);
        check("skip_no_pick_led", 32'(bus.led), 32'h000);
`else
        check("noskip_still", 32'(bus.state), 32'd3);
        wait_neg(2);
        check("noskip_last", 32'(bus.state), 32'd3);
        @(negedge clk);
        check("noskip_done", 32'(bus.state), 32'd1);
        wait_neg(2);
        check("noskip_no_pick_state", 32'(bus.state), 32'd1);
        check("noskip_no_pick_led", 32'(bus.led), 32'h000);
`endif

        // Attempts up to 99, including the 09 -> 10 carry
        n_att = 1;
        while (n_att < 99) begin
            n_att++;
            attempt(10'h001, 10'h002, bcd_of(n_att));
        end
        check("score_99", 32'(bus.score_bcd), 32'h99);

        // 100th attempt saturates; quit mid-REVEAL
        press(10'h001);
        press(10'h002);
        check("sat_state", 32'(bus.state), 32'd3);
        check("sat_score", 32'(bus.score_bcd), 32'h99);
        @(negedge clk);
        bus.quit = 1'b1;
        @(negedge clk);
        check("quit_rev_state", 32'(bus.state), 32'd0);
        check("quit_rev_led", 32'(bus.led), 32'h000);
        check("quit_rev_score", 32'(bus.score_bcd), 32'h00);
        bus.quit = 1'b0;

        // Asynchronous clear between edges
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        press(10'h020);
        check("pre_clr_state", 32'(bus.state), 32'd2);
        check("pre_clr_led", 32'(bus.led), 32'h020);
        #2;
        clear = 1'b0;
        #1;
        check("async_clr_state", 32'(bus.state), 32'd0);
        check("async_clr_led", 32'(bus.led), 32'h000);
        check("async_clr_hex", 32'(bus.first_hex), 32'hF);
        clear = 1'b1;
        wait_neg(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
